// File: rtl/alu_seq_if.sv
// Request/response channel between the datapath and the sequential ALU responder.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_alufn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_alu;
  logic        rsp_z;
  logic        rsp_v;
  logic        rsp_n;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_alufn, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_alu, rsp_z, rsp_v, rsp_n, rsp_illegal
  );

  modport slave (
    input  req_valid, req_alufn, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_alu, rsp_z, rsp_v, rsp_n, rsp_illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked 32-bit ALU responder; single-cycle ops plus an optional iterative shift-add MUL
// compiled in when ALU_SEQ_MUL_EN is defined (otherwise alufn 000010 decodes as illegal).
module alu_seq (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b011000;
  localparam logic [5:0] OpOr    = 6'b011110;
  localparam logic [5:0] OpXor   = 6'b010110;
  localparam logic [5:0] OpA     = 6'b011010;
  localparam logic [5:0] OpShl   = 6'b100000;
  localparam logic [5:0] OpShr   = 6'b100001;
  localparam logic [5:0] OpSra   = 6'b100011;
  localparam logic [5:0] OpCmpeq = 6'b110011;
  localparam logic [5:0] OpCmplt = 6'b110101;
  localparam logic [5:0] OpCmple = 6'b110111;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [5:0] OpMul   = 6'b000010;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] alu_q, alu_d;
  logic        z_q, z_d, v_q, v_d, n_q, n_d, ill_q, ill_d;
  logic        req_ready, accept;

  logic [31:0] b_eff, sum, res;
  logic        sub, ovf, use_sum, illegal, res_z, res_v, res_n;
`ifdef ALU_SEQ_MUL_EN
  logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_mul;
`endif

  // Every opcode except ADD uses the adder as a - b (SUB and the compares).
  always_comb begin
    sub     = (bus.req_alufn != OpAdd);
    b_eff   = sub ? ~bus.req_b : bus.req_b;
    sum     = bus.req_a + b_eff + {31'd0, sub};
    ovf     = (bus.req_a[31] == b_eff[31]) && (sum[31] != bus.req_a[31]);
    res     = '0;
    use_sum = 1'b0;
    illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    is_mul  = 1'b0;
`endif
    case (bus.req_alufn)
      OpAdd, OpSub: begin res = sum; use_sum = 1'b1; end
      OpAnd:        res = bus.req_a & bus.req_b;
      OpOr:         res = bus.req_a | bus.req_b;
      OpXor:        res = bus.req_a ^ bus.req_b;
      OpA:          res = bus.req_a;
      OpShl:        res = bus.req_a << bus.req_b[4:0];
      OpShr:        res = bus.req_a >> bus.req_b[4:0];
      OpSra:        res = $signed(bus.req_a) >>> bus.req_b[4:0];
      OpCmpeq:      begin res = {31'd0, sum == 32'd0}; use_sum = 1'b1; end
      OpCmplt:      begin res = {31'd0, sum[31] ^ ovf}; use_sum = 1'b1; end
      OpCmple:      begin res = {31'd0, (sum[31] ^ ovf) | (sum == 32'd0)}; use_sum = 1'b1; end
`ifdef ALU_SEQ_MUL_EN
      OpMul:        is_mul = 1'b1;
`endif
      default:      illegal = 1'b1;
    endcase
    res_z = use_sum ? (sum == 32'd0) : (res == 32'd0);
    res_n = use_sum ? sum[31] : res[31];
    res_v = use_sum & ovf;
  end

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    ill_d   = ill_q;
`ifdef ALU_SEQ_MUL_EN
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`endif
    req_ready = (state_q == StIdle) | ((state_q == StDone) & bus.rsp_ready);
    accept    = bus.req_valid & req_ready;

    case (state_q)
      StDone: if (bus.rsp_ready) state_d = StIdle;
`ifdef ALU_SEQ_MUL_EN
      StBusy: begin
        acc_d = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : 32'd0);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          alu_d   = acc_d;
          z_d     = (acc_d == 32'd0);
          v_d     = 1'b0;
          n_d     = acc_d[31];
          ill_d   = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    // An accept overrides the DONE->IDLE handoff so back-to-back requests see no bubble.
    if (accept) begin
      state_d = StDone;
      alu_d   = res;
      z_d     = res_z;
      v_d     = res_v;
      n_d     = res_n;
      ill_d   = illegal;
`ifdef ALU_SEQ_MUL_EN
      if (is_mul) begin
        state_d = StBusy;
        a_d     = bus.req_a;
        b_d     = bus.req_b;
        acc_d   = '0;
        cnt_d   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      alu_q   <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      ill_q   <= ill_d;
`ifdef ALU_SEQ_MUL_EN
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = (state_q == StDone);
  assign bus.rsp_alu     = alu_q;
  assign bus.rsp_z       = z_q;
  assign bus.rsp_v       = v_q;
  assign bus.rsp_n       = n_q;
  assign bus.rsp_illegal = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq, checked against an arithmetic reference model.
module tb_alu_seq;
  localparam logic [5:0] FnAdd = 6'b000000, FnSub = 6'b000001, FnMul = 6'b000010;
  localparam logic [5:0] FnAnd = 6'b011000, FnOr = 6'b011110, FnXor = 6'b010110;
  localparam logic [5:0] FnA = 6'b011010, FnShl = 6'b100000, FnShr = 6'b100001;
  localparam logic [5:0] FnSra = 6'b100011, FnCmpeq = 6'b110011, FnCmplt = 6'b110101;
  localparam logic [5:0] FnCmple = 6'b110111;
  localparam longint MaxS = 64'sh7fffffff;
  localparam longint MinS = -MaxS - 1;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        n;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_seq_if bus ();

  alu_seq u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, wide;
    logic   arith;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e     = '0;
    arith = 1'b0;
    wide  = sa - sb;
    case (fn)
      FnAdd:   begin wide = sa + sb; arith = 1'b1; e.r = 32'(wide); end
      FnSub:   begin arith = 1'b1; e.r = 32'(wide); end
      FnCmpeq: begin arith = 1'b1; e.r = (sa == sb) ? 32'd1 : 32'd0; end
      FnCmplt: begin arith = 1'b1; e.r = (sa < sb) ? 32'd1 : 32'd0; end
      FnCmple: begin arith = 1'b1; e.r = (sa <= sb) ? 32'd1 : 32'd0; end
`ifdef ALU_SEQ_MUL_EN
      FnMul:   e.r = a * b;
`endif
      FnAnd:   e.r = a & b;
      FnOr:    e.r = a | b;
      FnXor:   e.r = a ^ b;
      FnA:     e.r = a;
      FnShl:   e.r = a << b[4:0];
      FnShr:   e.r = a >> b[4:0];
      FnSra:   e.r = 32'(sa >>> b[4:0]);
      default: e.ill = 1'b1;
    endcase
    if (arith) begin
      e.z = (32'(wide) == 32'd0);
      e.n = wide[31];
      e.v = (wide > MaxS) || (wide < MinS);
    end else begin
      e.z = (e.r == 32'd0);
      e.n = e.r[31];
    end
    return e;
  endfunction

  function automatic int exp_latency(input logic [5:0] fn);
`ifdef ALU_SEQ_MUL_EN
    if (fn == FnMul) return 32;
`endif
    return 0;
  endfunction

  function automatic logic [35:0] rsp_vec();
    return {bus.rsp_alu, bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_illegal};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_alufn = fn;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic drop_req();
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom();
    bus.req_b     = $urandom();
  endtask

  // Accepts one op from IDLE, waits (bounded) for the response, checks it, then hands it off.
  task automatic do_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b);
    int   lat;
    logic ready_in_busy;
    present(fn, a, b);
    check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
    step();
    drop_req();
    lat           = 0;
    ready_in_busy = 1'b0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.req_ready) ready_in_busy = 1'b1;
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(fn)));
    if (lat > 0) check({tag, " req_ready low while busy"}, 64'(ready_in_busy), 64'd0);
    check({tag, " result"}, 64'(rsp_vec()), 64'(model(fn, a, b)));
    step();
  endtask

  initial begin
    exp_t        held;
    logic        saw_valid;
    logic [5:0]  fn;
    logic [31:0] ra, rb, rnd;
    logic [5:0]  legal [13];
    logic [31:0] corner [4];
    legal  = '{FnAdd, FnSub, FnMul, FnAnd, FnOr, FnXor, FnA, FnShl, FnShr, FnSra,
               FnCmpeq, FnCmplt, FnCmple};
    corner = '{32'h0, 32'h7fffffff, 32'h80000000, 32'hffffffff};

    bus.req_valid = 1'b0;
    bus.req_alufn = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("reset state", {bus.req_ready, bus.rsp_valid, rsp_vec()}, {1'b1, 1'b0, 36'd0});
    reset = 1'b0;
    step();
    check("idle after reset", {bus.req_ready, bus.rsp_valid}, 2'b10);

    do_op("add ovf", FnAdd, 32'h7fffffff, 32'h00000001);

    // SUB followed immediately by XOR with the consumer always ready.
    present(FnSub, 32'hffffff68, 32'hffffff34);
    step();
    present(FnXor, 32'hffffff68, 32'hffffff34);
    check("sub valid", 64'(bus.rsp_valid), 64'd1);
    check("sub result", 64'(rsp_vec()), 64'(model(FnSub, 32'hffffff68, 32'hffffff34)));
    check("sub ready for b2b", 64'(bus.req_ready), 64'd1);
    step();
    drop_req();
    check("xor b2b valid", 64'(bus.rsp_valid), 64'd1);
    check("xor b2b result", 64'(rsp_vec()), {28'd0, 32'h0000005c, 4'b0000});
    step();
    check("idle after b2b", 64'(bus.rsp_valid), 64'd0);

    do_op("mul", FnMul, 32'hffffffff, 32'hffffff34);
    do_op("cmplt", FnCmplt, 32'hff00ffff, 32'hffffff34);
    do_op("cmple eq", FnCmple, 32'hffffffff, 32'hffffffff);
    do_op("cmpeq ne", FnCmpeq, 32'hffffff68, 32'hffffff34);

    // Backpressure: response frozen, then handoff and new accept on the same edge.
    bus.rsp_ready = 1'b0;
    present(FnSra, 32'h80000000, 32'h00000024);
    step();
    drop_req();
    held = model(FnSra, 32'h80000000, 32'h00000024);
    for (int i = 0; i < 5; i++) begin
      check("sra held", {bus.rsp_valid, bus.req_ready, rsp_vec()}, {1'b1, 1'b0, held});
      step();
    end
    bus.rsp_ready = 1'b1;
    present(FnShl, 32'h00000003, 32'hffffffe5);
    #1;
    check("handoff ready", 64'(bus.req_ready), 64'd1);
    step();
    drop_req();
    check("shl after handoff", {bus.rsp_valid, rsp_vec()},
          {1'b1, model(FnShl, 32'h00000003, 32'hffffffe5)});
    step();

    // Reset mid-operation must abort with no stale response afterwards.
`ifdef ALU_SEQ_MUL_EN
    present(FnMul, 32'h12345678, 32'h9abcdef1);
    step();
    drop_req();
    for (int i = 0; i < 10; i++) step();
`else
    bus.rsp_ready = 1'b0;
    present(FnAdd, 32'h12345678, 32'h9abcdef1);
    step();
    drop_req();
    step();
    bus.rsp_ready = 1'b1;
`endif
    reset = 1'b1;
    step();
    check("abort reset values", {bus.req_ready, bus.rsp_valid, rsp_vec()}, {1'b1, 1'b0, 36'd0});
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) saw_valid = 1'b1;
      step();
    end
    check("no stale response", 64'(saw_valid), 64'd0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 15) < 13) begin
        fn = legal[$urandom_range(0, 12)];
      end else begin
        rnd = $urandom();
        fn  = rnd[5:0];
      end
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
      do_op($sformatf("rand%0d fn=%b", k, fn), fn, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, handshaked ALU responder for the processor datapath. It accepts one operation request at a time, using the datapath's 6-bit `alufn` encoding with 32-bit operands. It returns a registered result with z/v/n flags over a valid/ready response channel. Single-cycle ops respond in 1 cycle; MUL uses a 32-cycle iterative shift-add unit, so the core stalls on the handshake rather than on a long combinational path.

## Interface
- Parameters: none; width fixed at 32, alufn fixed at 6.
- Clock and reset are one clock; reset is synchronous and active-high.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_alufn` input 6: operation code.
- `req_a` input 32: operand A.
- `req_b` input 32: operand B.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer takes the response this cycle.
- `rsp_alu` output 32: result.
- `rsp_z` output 1: zero flag.
- `rsp_v` output 1: signed-overflow flag.
- `rsp_n` output 1: negative flag.
- `rsp_illegal` output 1: unrecognised alufn.

## Operation
- Opcodes:
  - ADD 000000, SUB 000001, MUL 000010.
  - AND 011000, OR 011110, XOR 010110, A (pass `req_a`) 011010.
  - SHL 100000, SHR 100001, SRA 100011.
  - CMPEQ 110011, CMPLT 110101, CMPLE 110111.
- Shift amount is `b[4:0]`; the upper bits of `b` are ignored.
- Compares are signed and produce result 32'h1 or 32'h0.
- Flags for ADD/SUB/CMP*:
  - Computed from the adder output (a+b for ADD, a−b otherwise).
  - z = sum==0, n = sum[31], v = two's-complement overflow.
- Flags for all other ops: z = result==0, n = result[31], v = 0.
- MUL returns the low 32 bits of the product; its v is 0.
- Illegal alufn: result 0, z=1, n=0, v=0, `rsp_illegal`=1; takes the single-cycle path.
- FSM:
  - IDLE: `req_ready`=1. An accepted non-MUL request goes to DONE with the result registered. An accepted MUL goes to BUSY with operands latched and cnt=0.
  - BUSY: `req_ready`=0. Each cycle adds `a<<cnt` when `b[cnt]`, then cnt++. After the cnt=31 step, go to DONE.
  - DONE: `rsp_valid`=1; response outputs held stable. On `rsp_ready`=1, leave DONE.
  - `req_ready` = IDLE | (DONE & `rsp_ready`).
  - A request accepted in DONE on the same cycle as the handoff is processed as if accepted from IDLE (back-to-back, no bubble).
  - On DONE with `rsp_ready`=1 and no new request, go to IDLE.
- Operands are latched at acceptance. Request inputs are don't-care outside accept cycles.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_alu`=0, `rsp_z`=0, `rsp_v`=0, `rsp_n`=0, `rsp_illegal`=0; state IDLE, cnt=0.
- Non-MUL latency: request accepted at edge E0 gives `rsp_valid`=1 after E0.
- MUL latency: accepted at E0, BUSY steps at E1..E32, `rsp_valid`=1 after E32.
- Throughput: 1 op per cycle for non-MUL under `rsp_ready`=1. MUL: 1 per 33 cycles.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs are frozen and `req_ready`=0.
- Reset mid-operation (BUSY or DONE): abort. The next cycle shows reset values, no response is emitted, and partial products are discarded.
- Reset has priority over a simultaneous accept or handoff.

## Configuration
- `ALU_SEQ_MUL_EN` defined: iterative multiplier and BUSY state compiled in; MUL behaves as above.
- `ALU_SEQ_MUL_EN` undefined: multiplier and BUSY state removed. alufn 000010 is treated as illegal (result 0, `rsp_illegal`=1, 1-cycle latency).

## Test plan
- ADD a=32'h7fffffff b=32'h00000001 → alu=32'h80000000, v=1, n=1, z=0; `rsp_valid` 1 cycle after accept.
- SUB a=32'hffffff68 b=32'hffffff34 → alu=32'h00000034, z=0, v=0, n=0. Follow back-to-back with XOR of the same operands, with `rsp_ready` held 1 → alu=32'h0000005c on the very next cycle.
- MUL a=32'hffffffff b=32'hffffff34 → alu=32'h000000cc after exactly 32 BUSY cycles, with `req_ready`=0 throughout. Without `ALU_SEQ_MUL_EN` → `rsp_illegal`=1, alu=0 after 1 cycle.
- CMPLT a=32'hff00ffff b=32'hffffff34 → alu=1. CMPLE a=b=32'hffffffff → alu=1, z=1. CMPEQ a=32'hffffff68 b=32'hffffff34 → alu=0.
- SRA a=32'h80000000 b=32'h00000024 (shift 4) with `rsp_ready`=0 for 5 cycles → alu=32'hf8000000 held stable and `req_ready`=0. Then `rsp_ready`=1 while a new SHL is presented → handoff and acceptance in the same cycle.
- Reset asserted at BUSY cycle 10 of a MUL → next cycle `rsp_valid`=0, `req_ready`=1, all outputs 0. No stale response ever appears.
